// File: rtl/exa_crosb_pkg.sv
// Shared types and helpers for the crossbar input-side VC arbitration.
package exa_crosb_pkg;

  typedef enum logic {IDLE, XFER} vc_arb_state_t;

  // VC index k = class * vcs + in-class index
  function automatic int vc_class(input int k, input int vcs);
    return k / vcs;
  endfunction

  function automatic int vc_sub(input int k, input int vcs);
    return k % vcs;
  endfunction

endpackage

// File: rtl/exa_crosb_rr_picker.sv
// Round-robin first-one picker: lowest set request at or after ptr, wrapping.
module exa_crosb_rr_picker #(
  parameter int width = 2,
  parameter int ptr_w = (width > 1) ? $clog2(width) : 1
) (
  input  logic [width-1:0] req,
  input  logic [ptr_w-1:0] ptr,
  output logic             any,
  output logic [ptr_w-1:0] idx
);

  logic [ptr_w-1:0] j;

  // Scan farthest offset first so the nearest request to ptr is the last write.
  always_comb begin
    idx = '0;
    j   = '0;
    for (int i = width - 1; i >= 0; i--) begin
      j = ptr_w'((int'(ptr) + i) % width);
      if (req[j]) idx = j;
    end
  end

  assign any = |req;

endmodule

// File: rtl/exa_crosb_input_vc_arbiter.sv
// Per-input VC arbiter: strict priority across classes, round-robin within a class,
// packet lock. Optional anti-starvation guard under EXA_CROSB_VC_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no packet locked; arbitrate among eligible VCs
// XFER  | locked on o_selected_vc until its tail beat is dequeued
module exa_crosb_input_vc_arbiter
  import exa_crosb_pkg::*;
#(
  parameter int prio_num   = 2,
  parameter int vc_num     = 2,
  parameter int output_num = 4,
  parameter int logVcPrio  = $clog2(prio_num * vc_num),
  parameter int logOutput  = $clog2(output_num)
`ifdef EXA_CROSB_VC_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                                       Clk,
  input  logic                                       Reset,
  input  logic [prio_num*vc_num-1:0]                 i_has_packet,
  input  logic [prio_num*vc_num-1:0][logOutput-1:0]  i_dests,
  input  logic                                       i_tlast,
  input  logic [output_num-1:0][prio_num*vc_num-1:0] i_dest_ready,
  input  logic                                       i_out_tready,
  output logic [logVcPrio-1:0]                       o_selected_vc,
  output logic                                       o_cts,
  output logic                                       o_req_valid,
  output logic [logOutput-1:0]                       o_req_dest,
  output logic                                       o_prio
);

  localparam int N   = prio_num * vc_num;
  localparam int VW  = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int PRW = (prio_num > 1) ? $clog2(prio_num) : 1;

  vc_arb_state_t                 state;
  logic [N-1:0]                  eligible;
  logic [prio_num-1:0]           class_any;
  logic [prio_num-1:0][VW-1:0]   class_win;
  logic [prio_num-1:0][VW-1:0]   rr_ptr;
  logic [PRW-1:0]                win_class;
  logic [PRW-1:0]                sel_class;
  logic [logVcPrio-1:0]          winner;
  logic [VW-1:0]                 rr_next;
  logic                          tail;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N; k++) begin
      eligible[k] = i_has_packet[k] & i_dest_ready[i_dests[k]][k];
    end
  end

  for (genvar p = 0; p < prio_num; p++) begin : g_class
    exa_crosb_rr_picker #(
      .width (vc_num),
      .ptr_w (VW)
    ) u_pick (
      .req (eligible[p*vc_num +: vc_num]),
      .ptr (rr_ptr[p]),
      .any (class_any[p]),
      .idx (class_win[p])
    );
  end

`ifdef EXA_CROSB_VC_ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0] starve_cnt;
  logic           starve_hit;

  assign starve_hit = starve_cnt >= SCW'(STARVE_LIMIT);

  // Counts higher-class wins that bypassed a waiting class 0; saturates at the limit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && |class_any) begin
      if (win_class == '0) starve_cnt <= '0;
      else if (class_any[0] && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    win_class = '0;
    for (int p = 0; p < prio_num; p++) begin
      if (class_any[p]) win_class = PRW'(p);
    end
`ifdef EXA_CROSB_VC_ARB_STARVE_GUARD_EN
    if (starve_hit && class_any[0]) win_class = '0;
`endif
  end

  assign winner    = logVcPrio'(int'(win_class) * vc_num + int'(class_win[win_class]));
  assign sel_class = PRW'(vc_class(int'(o_selected_vc), vc_num));
  assign rr_next   = VW'((vc_sub(int'(o_selected_vc), vc_num) + 1) % vc_num);

  assign o_req_valid = (state == XFER);
  assign o_cts       = (state == XFER) & i_out_tready & i_has_packet[o_selected_vc];
  assign o_prio      = int'(o_selected_vc) >= vc_num;
  assign tail        = o_cts & i_tlast;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      o_selected_vc <= '0;
      o_req_dest    <= '0;
      rr_ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|class_any) begin
            o_selected_vc <= winner;
            o_req_dest    <= i_dests[winner];
            state         <= XFER;
          end
        end
        XFER: begin
          if (tail) begin
            rr_ptr[sel_class] <= rr_next;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exa_crosb_input_vc_arbiter.sv
// Directed bench for exa_crosb_input_vc_arbiter; guard expectations follow
// EXA_CROSB_VC_ARB_STARVE_GUARD_EN (instance built with STARVE_LIMIT = 2 then).
module tb_exa_crosb_input_vc_arbiter;

  localparam int N  = 4;
  localparam int NO = 4;
  localparam int LV = 2;
  localparam int LO = 2;

  logic                  Clk = 1'b0;
  logic                  Reset = 1'b1;
  logic [N-1:0]          i_has_packet;
  logic [N-1:0][LO-1:0]  i_dests;
  logic                  i_tlast;
  logic [NO-1:0][N-1:0]  i_dest_ready;
  logic                  i_out_tready;
  logic [LV-1:0]         o_selected_vc;
  logic                  o_cts;
  logic                  o_req_valid;
  logic [LO-1:0]         o_req_dest;
  logic                  o_prio;

  int checks = 0;
  int errors = 0;

  exa_crosb_input_vc_arbiter #(
    .prio_num   (2),
    .vc_num     (2),
    .output_num (4)
`ifdef EXA_CROSB_VC_ARB_STARVE_GUARD_EN
    , .STARVE_LIMIT (2)
`endif
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .i_has_packet  (i_has_packet),
    .i_dests       (i_dests),
    .i_tlast       (i_tlast),
    .i_dest_ready  (i_dest_ready),
    .i_out_tready  (i_out_tready),
    .o_selected_vc (o_selected_vc),
    .o_cts         (o_cts),
    .o_req_valid   (o_req_valid),
    .o_req_dest    (o_req_dest),
    .o_prio        (o_prio)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_g[4];
`ifdef EXA_CROSB_VC_ARB_STARVE_GUARD_EN
    exp_g = '{2, 2, 0, 2};
`else
    exp_g = '{2, 2, 2, 2};
`endif
    i_has_packet = '0;
    i_dests      = '0;
    i_tlast      = 1'b0;
    i_dest_ready = '1;
    i_out_tready = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    settle();
    chk("rst_sel", 32'(o_selected_vc), 0);
    chk("rst_dest", 32'(o_req_dest), 0);
    chk("rst_cts", 32'(o_cts), 0);
    chk("rst_req", 32'(o_req_valid), 0);
    chk("rst_prio", 32'(o_prio), 0);

    // single VC, 3-beat packet
    i_has_packet = 4'b0010;
    i_dests[1]   = 2'd2;
    settle();
    chk("t1_idle_req", 32'(o_req_valid), 0);
    tick(); settle();
    chk("t1_sel", 32'(o_selected_vc), 1);
    chk("t1_dest", 32'(o_req_dest), 2);
    chk("t1_req", 32'(o_req_valid), 1);
    for (int b = 0; b < 3; b++) begin
      i_tlast = (b == 2);
      settle();
      chk($sformatf("t1_cts_b%0d", b), 32'(o_cts), 1);
      tick();
    end
    i_has_packet = '0;
    settle();
    chk("t1_tail_req", 32'(o_req_valid), 0);
    chk("t1_tail_cts", 32'(o_cts), 0);
    chk("t1_hold_sel", 32'(o_selected_vc), 1);

    // class 1 beats class 0, then class 0 after one bubble
    i_has_packet = 4'b0101;
    i_dests[0]   = 2'd1;
    i_dests[2]   = 2'd3;
    i_tlast      = 1'b1;
    settle();
    tick(); settle();
    chk("t2_sel_hi", 32'(o_selected_vc), 2);
    chk("t2_prio_hi", 32'(o_prio), 1);
    chk("t2_dest_hi", 32'(o_req_dest), 3);
    chk("t2_cts_hi", 32'(o_cts), 1);
    tick();
    i_has_packet = 4'b0001;
    settle();
    chk("t2_bubble", 32'(o_req_valid), 0);
    tick(); settle();
    chk("t2_sel_lo", 32'(o_selected_vc), 0);
    chk("t2_prio_lo", 32'(o_prio), 0);
    chk("t2_dest_lo", 32'(o_req_dest), 1);
    tick();
    i_has_packet = '0;
    settle();

    // round-robin inside class 0 from a fresh reset
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    i_has_packet = 4'b0011;
    i_dests[0]   = 2'd1;
    i_dests[1]   = 2'd2;
    settle();
    for (int g = 0; g < 4; g++) begin
      tick(); settle();
      chk($sformatf("t3_sel_g%0d", g), 32'(o_selected_vc), 32'(g % 2));
      chk($sformatf("t3_cts_g%0d", g), 32'(o_cts), 1);
      tick();
      if (g == 3) i_has_packet = '0;
      settle();
      chk($sformatf("t3_bub_g%0d", g), 32'(o_req_valid), 0);
    end

    // tready 0,1,0,1 in XFER over a 2-beat packet
    i_has_packet = 4'b0100;
    i_dests[2]   = 2'd0;
    i_tlast      = 1'b0;
    i_out_tready = 1'b0;
    settle();
    tick();
    for (int c = 0; c < 4; c++) begin
      i_out_tready = (c % 2 == 1);
      i_tlast      = (c >= 2);
      settle();
      chk($sformatf("t4_cts_c%0d", c), 32'(o_cts), 32'(c % 2));
      chk($sformatf("t4_req_c%0d", c), 32'(o_req_valid), 1);
      tick();
    end
    i_has_packet = '0;
    settle();
    chk("t4_done", 32'(o_req_valid), 0);

    // lock survives dest_ready drop; underrun stalls cts
    i_out_tready = 1'b1;
    i_has_packet = 4'b0010;
    i_dests[1]   = 2'd2;
    i_tlast      = 1'b0;
    settle();
    tick(); settle();
    chk("t5_sel", 32'(o_selected_vc), 1);
    i_dest_ready = '0;
    settle();
    chk("t5_ready_drop_cts", 32'(o_cts), 1);
    tick();
    i_has_packet = '0;
    settle();
    chk("t5_underrun_cts", 32'(o_cts), 0);
    chk("t5_underrun_req", 32'(o_req_valid), 1);
    chk("t5_underrun_sel", 32'(o_selected_vc), 1);
    tick();
    i_has_packet = 4'b0010;
    i_tlast      = 1'b1;
    settle();
    chk("t5_resume_cts", 32'(o_cts), 1);
    tick();
    i_dest_ready = '1;
    i_has_packet = 4'b0001;
    settle();
    chk("t5_tail_req", 32'(o_req_valid), 0);
    tick(); settle();
    chk("t5_vc0_sel", 32'(o_selected_vc), 0);
    tick();
    i_has_packet = '0;
    settle();

    // reset on beat 2 of a 4-beat packet clears lock and pointers
    i_has_packet = 4'b1000;
    i_dests[3]   = 2'd1;
    i_tlast      = 1'b0;
    settle();
    tick(); settle();
    chk("t6_sel", 32'(o_selected_vc), 3);
    tick(); settle();
    chk("t6_beat2_cts", 32'(o_cts), 1);
    Reset = 1'b1;
    #1;
    chk("t6_async_cts", 32'(o_cts), 0);
    chk("t6_async_req", 32'(o_req_valid), 0);
    tick(); settle();
    chk("t6_next_cts", 32'(o_cts), 0);
    chk("t6_next_req", 32'(o_req_valid), 0);
    chk("t6_next_sel", 32'(o_selected_vc), 0);
    Reset        = 1'b0;
    i_has_packet = 4'b1111;
    i_dests[0]   = 2'd1;
    i_dests[1]   = 2'd2;
    i_dests[2]   = 2'd3;
    i_dests[3]   = 2'd1;
    i_tlast      = 1'b1;
    settle();
    tick(); settle();
    chk("t6_ptr1_sel", 32'(o_selected_vc), 2);
    tick();
    i_has_packet = 4'b0011;
    settle();
    tick(); settle();
    chk("t6_ptr0_sel", 32'(o_selected_vc), 0);
    tick();
    i_has_packet = '0;
    settle();

    // VC 0 and VC 2 continuously eligible
    i_has_packet = 4'b0101;
    settle();
    for (int g = 0; g < 4; g++) begin
      tick(); settle();
      chk($sformatf("t7_sel_g%0d", g), 32'(o_selected_vc), 32'(exp_g[g]));
      tick();
      if (g == 3) i_has_packet = '0;
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
